// File: rtl/chacha_ks_xor_stream_if.sv
// Payload, keystream and status bundle between the ChaCha keystream XOR engine
// and its environment; slave is the engine side, master is the driver side.
interface chacha_ks_xor_stream_if #(
    parameter int DATA_W = 128,
    parameter int KS_W   = 512
);
    logic                  start;
    logic                  ks_req;
    logic                  ks_valid;
    logic [KS_W-1:0]       ks_data;
    logic                  in_valid;
    logic [DATA_W-1:0]     in_data;
    logic [DATA_W/8-1:0]   in_keep;
    logic                  in_last;
    logic                  in_ready;
    logic                  out_valid;
    logic [DATA_W-1:0]     out_data;
    logic [DATA_W/8-1:0]   out_keep;
    logic                  out_last;
    logic                  out_ready;
    logic                  busy;
    logic [31:0]           blk_cnt;

    modport master (
        output start, ks_valid, ks_data, in_valid, in_data, in_keep, in_last, out_ready,
        input  ks_req, in_ready, out_valid, out_data, out_keep, out_last, busy, blk_cnt
    );

    modport slave (
        input  start, ks_valid, ks_data, in_valid, in_data, in_keep, in_last, out_ready,
        output ks_req, in_ready, out_valid, out_data, out_keep, out_last, busy, blk_cnt
    );
endinterface

// File: rtl/chacha_ks_xor_stream.sv
// Keystream prefetch FIFO plus XOR engine: slices KS_W-bit keystream blocks LSB-first
// into DATA_W segments and XORs one segment into each accepted payload beat.
module chacha_ks_xor_stream #(
    parameter int DATA_W   = 128,
    parameter int KS_W     = 512,
    parameter int KS_DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    chacha_ks_xor_stream_if.slave   bus
);

    localparam int KEEP_W = DATA_W / 8;
    localparam int NSEG   = KS_W / DATA_W;
    localparam int SEG_W  = (NSEG > 1) ? $clog2(NSEG) : 1;
    localparam int PTR_W  = (KS_DEPTH > 1) ? $clog2(KS_DEPTH) : 1;
    localparam int CNT_W  = $clog2(KS_DEPTH + 1);

    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(KS_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(KS_DEPTH - 1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [SEG_W-1:0] SEG_LAST = SEG_W'(NSEG - 1);
    localparam logic [SEG_W-1:0] SEG_ONE  = SEG_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    function automatic logic [DATA_W-1:0] byte_mask(input logic [KEEP_W-1:0] keep);
        logic [DATA_W-1:0] m;
        m = {DATA_W{1'b0}};
        for (int b = 0; b < KEEP_W; b++) begin
            m[8*b +: 8] = {8{keep[b]}};
        end
        return m;
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] r;
        if (p == PTR_LAST) begin
            r = {PTR_W{1'b0}};
        end else begin
            r = p + PTR_ONE;
        end
        return r;
    endfunction

    state_e              state_q, state_d;
    logic [KS_W-1:0]     fifo_q [KS_DEPTH];
    logic [KS_W-1:0]     fifo_d [KS_DEPTH];
    logic [PTR_W-1:0]    rd_q, rd_d;
    logic [PTR_W-1:0]    wr_q, wr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [SEG_W-1:0]    seg_idx_q, seg_idx_d;
    logic                outstanding_q, outstanding_d;
    logic                ks_req_q, ks_req_d;
    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic [KEEP_W-1:0]   out_keep_q, out_keep_d;
    logic                out_last_q, out_last_d;
    logic [31:0]         blk_cnt_q, blk_cnt_d;

    logic [KS_W-1:0]     head_s;
    logic [DATA_W-1:0]   seg_s;
    logic                in_ready_s;
    logic                accept_s;
    logic                ks_take_s;
    logic                push_s;
    logic                push_ok_s;
    logic                pop_s;
    logic                req_fire_s;
    logic                start_acc_s;
    logic                fifo_clr_s;

    // Handshake qualifiers and the segment currently at the head of the FIFO
    always_comb begin
        head_s      = fifo_q[rd_q];
        seg_s       = head_s[DATA_W*seg_idx_q +: DATA_W];
        in_ready_s  = (state_q == ST_RUN) && (cnt_q != {CNT_W{1'b0}}) &&
                      (!out_valid_q || bus.out_ready);
        accept_s    = bus.in_valid && in_ready_s;
        ks_take_s   = bus.ks_valid && outstanding_q;
        // Blocks landing while draining are swallowed, never buffered
        push_s      = ks_take_s && (state_q == ST_RUN);
        pop_s       = accept_s && (bus.in_last || (seg_idx_q == SEG_LAST));
        push_ok_s   = push_s && ((cnt_q < DEPTH_C) || pop_s);
        req_fire_s  = (state_q == ST_RUN) && !outstanding_q && (cnt_q < DEPTH_C);
        start_acc_s = (state_q == ST_IDLE) && bus.start;
    end

    // Message FSM: next state and FIFO-clear events
    always_comb begin
        state_d    = state_q;
        fifo_clr_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d    = ST_RUN;
                    fifo_clr_s = 1'b1;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (accept_s && bus.in_last) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (!outstanding_q) begin
                    state_d    = ST_IDLE;
                    fifo_clr_s = 1'b1;
                end else begin
                    state_d    = ST_DRAIN;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                fifo_clr_s = 1'b1;
            end
        endcase
    end

    // Keystream request tracking and FIFO pointer/count update
    always_comb begin
        outstanding_d = outstanding_q;
        ks_req_d      = req_fire_s;
        fifo_d        = fifo_q;
        rd_d          = rd_q;
        wr_d          = wr_q;
        cnt_d         = cnt_q;
        if (ks_take_s) begin
            outstanding_d = 1'b0;
        end else if (req_fire_s) begin
            outstanding_d = 1'b1;
        end else begin
            outstanding_d = outstanding_q;
        end
        if (fifo_clr_s) begin
            rd_d  = {PTR_W{1'b0}};
            wr_d  = {PTR_W{1'b0}};
            cnt_d = {CNT_W{1'b0}};
        end else begin
            if (pop_s) begin
                rd_d = ptr_inc(rd_q);
            end else begin
                rd_d = rd_q;
            end
            // Full FIFO with a pop: the tail slot equals the old head slot, order holds
            if (push_ok_s) begin
                fifo_d[wr_q] = bus.ks_data;
                wr_d         = ptr_inc(wr_q);
            end else begin
                wr_d = wr_q;
            end
            case ({push_ok_s, pop_s})
                2'b10:   cnt_d = cnt_q + CNT_ONE;
                2'b01:   cnt_d = cnt_q - CNT_ONE;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Segment index, block counter and the registered output beat
    always_comb begin
        seg_idx_d   = seg_idx_q;
        blk_cnt_d   = blk_cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_keep_d  = out_keep_q;
        out_last_d  = out_last_q;
        if (fifo_clr_s) begin
            seg_idx_d = {SEG_W{1'b0}};
        end else if (accept_s) begin
            seg_idx_d = pop_s ? {SEG_W{1'b0}} : (seg_idx_q + SEG_ONE);
        end else begin
            seg_idx_d = seg_idx_q;
        end
        if (start_acc_s) begin
            blk_cnt_d = 32'd0;
        end else if (accept_s && (seg_idx_q == {SEG_W{1'b0}})) begin
            blk_cnt_d = blk_cnt_q + 32'd1;
        end else begin
            blk_cnt_d = blk_cnt_q;
        end
        if (accept_s) begin
            out_valid_d = 1'b1;
            out_data_d  = (bus.in_data ^ seg_s) & byte_mask(bus.in_keep);
            out_keep_d  = bus.in_keep;
            out_last_d  = bus.in_last;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            for (int i = 0; i < KS_DEPTH; i++) begin
                fifo_q[i] <= {KS_W{1'b0}};
            end
            rd_q          <= {PTR_W{1'b0}};
            wr_q          <= {PTR_W{1'b0}};
            cnt_q         <= {CNT_W{1'b0}};
            seg_idx_q     <= {SEG_W{1'b0}};
            outstanding_q <= 1'b0;
            ks_req_q      <= 1'b0;
            out_valid_q   <= 1'b0;
            out_data_q    <= {DATA_W{1'b0}};
            out_keep_q    <= {KEEP_W{1'b0}};
            out_last_q    <= 1'b0;
            blk_cnt_q     <= 32'd0;
        end else begin
            state_q       <= state_d;
            fifo_q        <= fifo_d;
            rd_q          <= rd_d;
            wr_q          <= wr_d;
            cnt_q         <= cnt_d;
            seg_idx_q     <= seg_idx_d;
            outstanding_q <= outstanding_d;
            ks_req_q      <= ks_req_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            out_keep_q    <= out_keep_d;
            out_last_q    <= out_last_d;
            blk_cnt_q     <= blk_cnt_d;
        end
    end

    assign bus.ks_req    = ks_req_q;
    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_keep  = out_keep_q;
    assign bus.out_last  = out_last_q;
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.blk_cnt   = blk_cnt_q;

endmodule

// File: tb/tb_chacha_ks_xor_stream.sv
// Directed bench: keystream responder, scoreboard queue of expected beats, output monitor.
module tb_chacha_ks_xor_stream;

    localparam int DW   = 128;
    localparam int KW   = 512;
    localparam int KD   = 2;
    localparam int KEEP = DW / 8;

    typedef struct packed {
        logic [DW-1:0]   d;
        logic [KEEP-1:0] k;
        logic            l;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   msg_id = 0;
    int   req_cnt = 0;
    int   spur_go = 0;

    chacha_ks_xor_stream_if #(.DATA_W(DW), .KS_W(KW)) bus ();

    chacha_ks_xor_stream #(.DATA_W(DW), .KS_W(KW), .KS_DEPTH(KD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [KW-1:0] ks_block(input int m, input int b);
        logic [KW-1:0] r;
        for (int i = 0; i < KW/32; i++) begin
            r[32*i +: 32] = (32'(m) * 32'h0100_0193) ^ (32'(b) * 32'h9E37_79B9) ^
                            (32'(i) * 32'h85EB_CA6B) ^ 32'h5A5A_C3C3;
        end
        return r;
    endfunction

    function automatic logic [DW-1:0] seg_of(input int m, input int j);
        logic [KW-1:0] blk;
        blk = ks_block(m, j / (KW/DW));
        return blk[DW*(j % (KW/DW)) +: DW];
    endfunction

    function automatic logic [DW-1:0] kmask(input logic [KEEP-1:0] k);
        logic [DW-1:0] m;
        for (int b = 0; b < KEEP; b++) m[8*b +: 8] = {8{k[b]}};
        return m;
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Keystream source: answers each ks_req one cycle later; block content keyed by message
    initial begin
        int cur;
        int bi;
        int spur_seen;
        cur = -1;
        bi = 0;
        spur_seen = 0;
        bus.ks_valid = 1'b0;
        bus.ks_data  = {KW{1'b0}};
        forever begin
            @(negedge clk);
            bus.ks_valid = 1'b0;
            if (bus.ks_req) begin
                req_cnt++;
                if (msg_id != cur) begin
                    cur = msg_id;
                    bi = 0;
                end
                @(negedge clk);
                bus.ks_valid = 1'b1;
                bus.ks_data  = ks_block(cur, bi);
                bi++;
            end else if (spur_go != spur_seen) begin
                spur_seen = spur_go;
                bus.ks_valid = 1'b1;
                bus.ks_data  = {(KW/32){32'hDEAD_BEEF}};
            end
        end
    end

    // Output monitor: pops the scoreboard on every output handshake
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (bus.out_valid && bus.out_ready) begin
                total++;
                assert (exp_q.size() > 0) else begin
                    bad++;
                    $error("FAIL out_unexpected observed=%h expected=none", bus.out_data);
                end
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("out_data", bus.out_data, e.d);
                    chk("out_keep", DW'(bus.out_keep), DW'(e.k));
                    chk("out_last", DW'(bus.out_last), DW'(e.l));
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic drive_beat(input int m, input int j, input logic [DW-1:0] d,
                              input logic [KEEP-1:0] k, input logic l);
        exp_t e;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_keep  = k;
        bus.in_last  = l;
        e.d = (d ^ seg_of(m, j)) & kmask(k);
        e.k = k;
        e.l = l;
        exp_q.push_back(e);
    endtask

    task automatic wait_accept(input string tag);
        int n;
        n = 0;
        #1;
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        total++;
        assert (n < 100) else begin
            bad++;
            $error("FAIL %s observed=no_accept expected=accept", tag);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic send(input int m, input int j, input logic [DW-1:0] d,
                        input logic [KEEP-1:0] k, input logic l);
        drive_beat(m, j, d, k, l);
        wait_accept($sformatf("accept_m%0d_b%0d", m, j));
    endtask

    task automatic do_start(input int m);
        msg_id = m;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (bus.busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(tag, DW'(bus.busy), DW'(1'b0));
    endtask

    initial begin
        logic [DW-1:0] e0;
        int base;
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = {DW{1'b0}};
        bus.in_keep   = {KEEP{1'b0}};
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", DW'(bus.out_valid), DW'(1'b0));
        chk("rst_ks_req", DW'(bus.ks_req), DW'(1'b0));
        chk("rst_busy", DW'(bus.busy), DW'(1'b0));
        chk("rst_in_ready", DW'(bus.in_ready), DW'(1'b0));
        chk("rst_out_data", bus.out_data, {DW{1'b0}});
        chk("rst_blk_cnt", DW'(bus.blk_cnt), DW'(32'd0));
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("idle_no_req", DW'(bus.ks_req), DW'(1'b0));
        end

        // Four beats over one block, fifth beat crosses into the second block
        do_start(0);
        base = req_cnt;
        send(0, 0, 128'hAAAABBBBCCCCDDDDEEEEFFFF00001111, 16'hFFFF, 1'b0);
        chk("latency_out_valid", DW'(bus.out_valid), DW'(1'b1));
        chk("blk_cnt_b0", DW'(bus.blk_cnt), DW'(32'd1));
        send(0, 1, 128'h0123456789ABCDEF_FEDCBA9876543210, 16'hFFFF, 1'b0);
        send(0, 2, 128'hDEADBEEF_CAFEF00D_0BADC0DE_FEEDFACE, 16'hFFFF, 1'b0);
        #1;
        chk("second_req_before_p3", DW'(req_cnt - base), DW'(2));
        send(0, 3, 128'h5555AAAA_3333CCCC_0F0F0F0F_F0F0F0F0, 16'hFFFF, 1'b0);
        chk("blk_cnt_b3", DW'(bus.blk_cnt), DW'(32'd1));
        send(0, 4, 128'h1234567890ABCDEF1234567890ABCDEF, 16'hFFFF, 1'b1);
        chk("blk_cnt_b4", DW'(bus.blk_cnt), DW'(32'd2));
        wait_idle("idle_after_m0");

        // Short message ending mid-block with partial keep
        do_start(1);
        send(1, 0, 128'h11112222_33334444_55556666_77778888, 16'hFFFF, 1'b0);
        send(1, 1, 128'h99990000_AAAABBBB_CCCCDDDD_EEEEFFFF, 16'hFFFF, 1'b0);
        send(1, 2, 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, 16'h000F, 1'b1);
        chk("blk_cnt_m1", DW'(bus.blk_cnt), DW'(32'd1));
        wait_idle("idle_after_m1");

        // Backpressure: output held, no second accept, prefetch capped at KS_DEPTH blocks
        do_start(2);
        base = req_cnt;
        bus.out_ready = 1'b0;
        send(2, 0, 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0, 16'hFFFF, 1'b0);
        e0 = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0 ^ seg_of(2, 0);
        drive_beat(2, 1, 128'h13579BDF_2468ACE0_FDB97531_0ECA8642, 16'hFFFF, 1'b0);
        repeat (6) begin
            #1;
            chk("stall_out_data", bus.out_data, e0);
            chk("stall_in_ready", DW'(bus.in_ready), DW'(1'b0));
            @(negedge clk);
        end
        chk("req_cap_depth", DW'(req_cnt - base), DW'(KD));
        bus.out_ready = 1'b1;
        wait_accept("accept_m2_b1");
        send(2, 2, 128'hA5A5A5A5_5A5A5A5A_A5A5A5A5_5A5A5A5A, 16'hFFFF, 1'b0);
        send(2, 3, 128'h00000000_00000000_00000000_00000001, 16'hFFFF, 1'b0);
        send(2, 4, 128'h80000000_00000000_00000000_00000000, 16'hFFFF, 1'b1);
        chk("blk_cnt_m2", DW'(bus.blk_cnt), DW'(32'd2));
        wait_idle("idle_after_m2");

        // Spurious keystream in IDLE, then start pulse during RUN
        spur_go++;
        repeat (3) @(negedge clk);
        chk("spur_busy", DW'(bus.busy), DW'(1'b0));
        chk("spur_blk_cnt", DW'(bus.blk_cnt), DW'(32'd2));
        do_start(3);
        send(3, 0, 128'hC0FFEE00_C0FFEE11_C0FFEE22_C0FFEE33, 16'hFFFF, 1'b0);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("start_in_run_busy", DW'(bus.busy), DW'(1'b1));
        chk("start_in_run_blk", DW'(bus.blk_cnt), DW'(32'd1));
        send(3, 1, 128'hBEEFBEEF_BEEFBEEF_BEEFBEEF_BEEFBEEF, 16'hFFFF, 1'b0);
        send(3, 2, 128'h7777_6666_5555_4444_3333_2222_1111_0000, 16'hF0F0, 1'b1);
        wait_idle("idle_after_m3");

        // Reset in the middle of a message abandons the pending beat
        do_start(4);
        bus.out_ready = 1'b0;
        send(4, 0, 128'h31415926_53589793_23846264_33832795, 16'hFFFF, 1'b0);
        chk("pre_rst_out_valid", DW'(bus.out_valid), DW'(1'b1));
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", DW'(bus.out_valid), DW'(1'b0));
        chk("midrst_out_data", bus.out_data, {DW{1'b0}});
        chk("midrst_out_keep", DW'(bus.out_keep), DW'(16'h0000));
        chk("midrst_out_last", DW'(bus.out_last), DW'(1'b0));
        chk("midrst_busy", DW'(bus.busy), DW'(1'b0));
        chk("midrst_in_ready", DW'(bus.in_ready), DW'(1'b0));
        chk("midrst_ks_req", DW'(bus.ks_req), DW'(1'b0));
        chk("midrst_blk_cnt", DW'(bus.blk_cnt), DW'(32'd0));
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            #1;
            chk("post_rst_busy", DW'(bus.busy), DW'(1'b0));
            chk("post_rst_ks_req", DW'(bus.ks_req), DW'(1'b0));
            chk("post_rst_out_valid", DW'(bus.out_valid), DW'(1'b0));
        end

        total++;
        assert (exp_q.size() == 0) else begin
            bad++;
            $error("FAIL scoreboard_drained observed=%0d expected=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
